// File: rtl/sm_datapath_if.sv
// Product hand-off bundle between the multiplier datapath and its consumer.
// Ports: product (2N), product_valid (producer -> consumer), product_ready (consumer -> producer).
interface sm_datapath_if #(
    parameter int NUM_BITS = 4
);
    logic [2*NUM_BITS-1:0] product;
    logic                  product_valid;
    logic                  product_ready;

    modport master (
        output product,
        output product_valid,
        input  product_ready
    );

    modport slave (
        input  product,
        input  product_valid,
        output product_ready
    );
endinterface

// File: rtl/sm_datapath.sv
// Shift-add multiplier datapath: MD/MR operand registers, {C,RS} running sum,
// and a product holding register offered over a valid/ready handshake.
// Ports: clk, rst (async, active high); md_in/mr_in operands; mdld, mrld,
// rsload, rsclear, rsshr, done strobes from the controller; mr fed back;
// rs for visibility; prod_if (master) carries product/valid/ready; overrun.
// Optional feature: define SM_DP_OVERRUN_EN to preserve an unconsumed
// product on a conflicting capture and raise the sticky overrun flag.
module sm_datapath #(
    parameter int NUM_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_BITS-1:0]   md_in,
    input  logic [NUM_BITS-1:0]   mr_in,
    input  logic                  mdld,
    input  logic                  mrld,
    input  logic                  rsload,
    input  logic                  rsclear,
    input  logic                  rsshr,
    input  logic                  done,
    output logic [NUM_BITS-1:0]   mr,
    output logic [2*NUM_BITS-1:0] rs,
    sm_datapath_if.master         prod_if,
    output logic                  overrun
);

    localparam int N  = NUM_BITS;
    localparam int N2 = 2 * NUM_BITS;

    logic [N-1:0]  md_q, md_d;
    logic [N-1:0]  mr_q, mr_d;
    logic [N2-1:0] rs_q, rs_d;
    logic          c_q, c_d;
    logic          done_q, done_d;
    logic [N2-1:0] prod_q, prod_d;
    logic          valid_q, valid_d;
`ifdef SM_DP_OVERRUN_EN
    logic          ovr_q, ovr_d;
`endif

    logic [N:0]    sum;
    logic          capture;

    // Upper half of RS plus MD, with the carry-out kept as bit N.
    assign sum     = {1'b0, rs_q[N2-1:N]} + {1'b0, md_q};
    assign capture = done && !done_q;

    always_comb begin
        md_d   = md_q;
        mr_d   = mr_q;
        rs_d   = rs_q;
        c_d    = c_q;
        done_d = done;

        if (mdld) begin
            md_d = md_in;
        end
        if (mrld) begin
            mr_d = mr_in;
        end

        if (rsclear) begin
            rs_d = '0;
            c_d  = 1'b0;
        end else if (rsload && rsshr) begin
            // Add and shift in one edge: the sum's carry lands in the MSB
            // of RS and C receives the shifted-in zero.
            rs_d = {sum, rs_q[N-1:1]};
            c_d  = 1'b0;
        end else if (rsload) begin
            rs_d = {sum[N-1:0], rs_q[N-1:0]};
            c_d  = sum[N];
        end else if (rsshr) begin
            rs_d = {c_q, rs_q[N2-1:1]};
            c_d  = 1'b0;
        end
    end

    always_comb begin
        prod_d  = prod_q;
        valid_d = valid_q;
`ifdef SM_DP_OVERRUN_EN
        ovr_d   = ovr_q;
        if (capture) begin
            if (valid_q && !prod_if.product_ready) begin
                // Consumer still owns the old product: keep it, flag the loss.
                ovr_d = 1'b1;
            end else begin
                prod_d  = rs_q;
                valid_d = 1'b1;
            end
        end else if (valid_q && prod_if.product_ready) begin
            valid_d = 1'b0;
        end
`else
        if (capture) begin
            prod_d  = rs_q;
            valid_d = 1'b1;
        end else if (valid_q && prod_if.product_ready) begin
            valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_q    <= '0;
            mr_q    <= '0;
            rs_q    <= '0;
            c_q     <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            md_q    <= md_d;
            mr_q    <= mr_d;
            rs_q    <= rs_d;
            c_q     <= c_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
            valid_q <= valid_d;
        end
    end

`ifdef SM_DP_OVERRUN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun = ovr_q;
`else
    assign overrun = 1'b0;
`endif

    assign mr                    = mr_q;
    assign rs                    = rs_q;
    assign prod_if.product       = prod_q;
    assign prod_if.product_valid = valid_q;

endmodule

// File: doc/sm_datapath.md
# sm_datapath

Datapath for the shift-add sequential multiplier. It sits directly downstream of the SMControl controller. It consumes the controller's register-control strobes (mdld, mrld, rsload, rsclear, rsshr, done) and returns the multiplier register contents (mr) to the controller. Completed products are latched into a holding register and offered to the consumer over a valid/ready handshake.

## Interface
- NUM_BITS, 4, operand width N; product width is 2N.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- md_in  input  N  multiplicand operand.
- mr_in  input  N  multiplier operand.
- mdld  input  1  load MD from md_in.
- mrld  input  1  load MR from mr_in.
- rsload  input  1  add MD into the upper half of RS.
- rsclear  input  1  clear RS and the carry bit.
- rsshr  input  1  shift {C,RS} right by one.
- done  input  1  controller done level.
- mr  output  N  MR register contents, fed back to the controller.
- rs  output  2N  running-sum register, for debug and visibility.
- product  output  2N  holding register for the completed product.
- product_valid  output  1  product holds unconsumed data.
- product_ready  input  1  consumer accepts the product.
- overrun  output  1  sticky flag: a completed result was lost.

## Operation
- Internal state:
  - MD: N bits.
  - MR: N bits.
  - RS: 2N bits.
  - C: 1-bit carry.
  - done_q: 1 bit, previous value of done.
  - PROD: 2N bits.
  - VALID: 1 bit.
  - OVR: 1 bit.
- mdld and mrld act independently and may be asserted in the same cycle as any other strobe.
- RS update priority, evaluated each edge:
  - rsclear: {C,RS} <= 0. Overrides rsload and rsshr.
  - rsload only: {C, RS[2N-1:N]} <= RS[2N-1:N] + MD, computed as an (N+1)-bit sum. RS[N-1:0] is unchanged.
  - rsshr only: {C,RS} <= {1'b0, C, RS[2N-1:1]}.
  - rsload and rsshr together: the add is performed, then the (2N+1)-bit result {sum, RS[N-1:0]} is shifted right by one in the same edge, with 0 shifted into C.
  - No strobe: hold.
- Capture event: done=1 and done_q=0, i.e. a rising edge of the done level. On a capture event the RS value before this edge's update is the product.
- Handshake:
  - VALID is set on capture.
  - VALID is cleared on an edge where VALID=1 and product_ready=1 and no capture occurs.
  - Capture while VALID=1 and product_ready=1: PROD reloads and VALID stays 1. No overrun.
  - Capture while VALID=1 and product_ready=0: PROD keeps its old value and OVR is set (see Configuration).
  - product_ready while VALID=0 has no effect.
- OVR is cleared only by rst.

## Timing
- Reset values (applied immediately on rst, without waiting for clk): mr=0, rs=0, C=0, product=0, product_valid=0, overrun=0, done_q=0.
- All loads, adds and shifts take effect at the edge where the strobe is sampled. Results are visible on the outputs one cycle after the strobe.
- mr is registered; the controller sees a new multiplier one cycle after mrld.
- Capture latency: product and product_valid update at the edge that samples the first done=1 cycle. Holding done high for further cycles does not produce another capture.
- Consumption is visible one cycle after the accepting edge.
- rst during accumulation aborts the operation and discards any pending product.

## Configuration
- SM_DP_OVERRUN_EN:
  - Defined: overrun detection as described above. The old product is preserved on a conflicting capture and overrun goes high and stays high.
  - Undefined: overrun is tied to 0. A capture always reloads PROD and sets VALID, overwriting any unconsumed product.

## Test plan
- Reset value check, N=4:
  - Stimulus: drive mdld=1, md_in=4'hF for one cycle, then assert rst between clock edges.
  - Response: all outputs read 0 immediately, before the next clk edge.
- Carry path:
  - Stimulus: MD=4'hF; rsclear; rsload; rsload.
  - Response: rs=8'hE0 with C=1. Then rsshr gives rs=8'hF0.
- Full multiply, MD=13, MR=11:
  - Stimulus: for each i=0..3, apply rsload+rsshr if mr[i], else rsshr alone; then pulse done.
  - Response: product=8'h8F and product_valid=1. Repeat with MD=MR=15: product=8'hE1.
- Handshake:
  - Stimulus: hold done high for 3 cycles with product_ready=0.
  - Response: exactly one capture. Then product_ready=1 for one cycle gives product_valid=0 on the next cycle.
- Overrun (macro defined):
  - Stimulus: capture 8'h8F, then capture again with product_ready=0.
  - Response: product stays 8'h8F and overrun=1 until rst.
  - With the macro undefined, the same stimulus gives product equal to the new value and overrun=0.
- Simultaneous capture and accept:
  - Stimulus: VALID=1, product_ready=1, done rising edge.
  - Response: new product loaded, product_valid remains 1, overrun=0.
